uart_rx_ctrl: RTL and testbench

Receive-side controller for the `uart_rx` datapath. It gates the receiver's enable, detects each new-byte indication and buffers bytes in a small first-word-fall-through FIFO. It presents the bytes to the CPU through a valid/ready handshake and reports overrun, fill level and line-idle events. It sits between `uart_rx` and the forth_cpu I/O port, and sequences clean enable and disable of reception.

---
 rtl/uart_rx_ctrl_pkg.sv | 13 +
 rtl/uart_rx_ctrl_sync_fifo.sv | 52 +++++
 rtl/uart_rx_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller:
// FSM state encodings and the default byte width.
package uart_rx_ctrl_pkg;

   localparam int UART_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/uart_rx_ctrl_sync_fifo.sv
// First-word-fall-through FIFO: head entry is always visible on o_head.
// Callers must not push when full without a pop, nor pop when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_data,
   output logic [WIDTH-1:0]       o_head,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(i_push);
      rd_ptr_d = rd_ptr_q + PW'(i_pop);
      count_d  = count_q + CW'(i_push) - CW'(i_pop);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by count.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   assign o_head  = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: enable sequencing, new-byte edge detect,
// byte buffering, overrun and line-idle reporting.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int WIDTH        = UART_WIDTH,
   parameter int DEPTH        = 4,
   parameter int ALMOST_FULL  = 3,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_en,
   output logic                   o_rx_en,
   input  logic [WIDTH-1:0]       i_rx_data,
   input  logic                   i_rx_new,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_almost_full,
   output logic                   o_overrun,
   input  logic                   i_clr_overrun,
   output logic                   o_idle,
   output logic                   o_busy
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(IDLE_TIMEOUT);
   localparam logic [TW-1:0] TMR_MAX = TW'(IDLE_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic             rx_en_q, rx_en_d;
   logic             new_prev_q, new_prev_d;
   logic             overrun_q, overrun_d;
   logic             almost_full_q, almost_full_d;
   logic             idle_q, idle_d;
   logic             armed_q, armed_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [CW-1:0]    count, count_nxt;
   logic [WIDTH-1:0] head;
   logic             valid, full, push_ev, push, pop, drop;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_pop   (pop),
      .i_data  (i_rx_data),
      .o_head  (head),
      .o_count (count)
   );

   assign valid     = (count != '0);
   assign full      = (count == CW'(DEPTH));
   assign pop       = valid & i_ready;
   assign push_ev   = i_rx_new & ~new_prev_q & (state_q == ST_RUN);
   // A full FIFO still accepts a byte when the head leaves this cycle.
   assign push      = push_ev & (~full | pop);
   assign drop      = push_ev & full & ~pop;
   assign count_nxt = count + CW'(push) - CW'(pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_OFF: begin
            if (i_en) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!i_en) state_d = valid ? ST_DRAIN : ST_OFF;
         end
         ST_DRAIN: begin
            if (i_en)        state_d = ST_RUN;
            else if (!valid) state_d = ST_OFF;
         end
         default: state_d = ST_OFF;
      endcase
   end

   always_comb begin
      // Rises a cycle after RUN is entered, falls as RUN is left.
      rx_en_d       = (state_q == ST_RUN) && (state_d == ST_RUN);
      new_prev_d    = i_rx_new;
      overrun_d     = drop | (overrun_q & ~i_clr_overrun);
      almost_full_d = (count_nxt >= CW'(ALMOST_FULL));
      tmr_d         = tmr_q;
      armed_d       = armed_q;
      idle_d        = 1'b0;
      if ((state_q != ST_RUN) || (state_d != ST_RUN)) begin
         tmr_d   = '0;
         armed_d = 1'b0;
      end else if (push_ev) begin
         tmr_d   = '0;
         armed_d = 1'b1;
      end else if (tmr_q != TMR_MAX) begin
         tmr_d = tmr_q + TW'(1);
         if (armed_q && (tmr_d == TMR_MAX)) begin
            idle_d  = 1'b1;
            armed_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_en_q       <= 1'b0;
         new_prev_q    <= 1'b0;
         overrun_q     <= 1'b0;
         almost_full_q <= 1'b0;
         idle_q        <= 1'b0;
         armed_q       <= 1'b0;
         tmr_q         <= '0;
      end else begin
         rx_en_q       <= rx_en_d;
         new_prev_q    <= new_prev_d;
         overrun_q     <= overrun_d;
         almost_full_q <= almost_full_d;
         idle_q        <= idle_d;
         armed_q       <= armed_d;
         tmr_q         <= tmr_d;
      end
   end

   assign o_rx_en       = rx_en_q;
   assign o_valid       = valid;
   assign o_data        = valid ? head : '0;
   assign o_count       = count;
   assign o_almost_full = almost_full_q;
   assign o_overrun     = overrun_q;
   assign o_idle        = idle_q;
   assign o_busy        = (state_q != ST_OFF);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scenario bench for uart_rx_ctrl with a byte scoreboard queue.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       rx_en;
   logic [7:0] rx_data;
   logic       rx_new;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic [2:0] count;
   logic       afull;
   logic       ovr;
   logic       clr_ovr;
   logic       idle;
   logic       busy;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] sb [$];

   uart_rx_ctrl #(
      .WIDTH        (8),
      .DEPTH        (4),
      .ALMOST_FULL  (3),
      .IDLE_TIMEOUT (16)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .o_rx_en       (rx_en),
      .i_rx_data     (rx_data),
      .i_rx_new      (rx_new),
      .o_data        (data),
      .o_valid       (valid),
      .i_ready       (ready),
      .o_count       (count),
      .o_almost_full (afull),
      .o_overrun     (ovr),
      .i_clr_overrun (clr_ovr),
      .o_idle        (idle),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accept);
      rx_data = b;
      rx_new  = 1'b1;
      if (accept) sb.push_back(b);
      tick();
      rx_new = 1'b0;
      tick();
   endtask

   task automatic drain_sb(input string tag);
      logic [7:0] exp;
      ready = 1'b1;
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         checks++;
         if (valid !== 1'b1 || data !== exp) begin
            failures++;
            $display("FAIL %s pop: valid=%b data=%h required valid=1 data=%h",
                     tag, valid, data, exp);
         end
         tick();
      end
      ready = 1'b0;
      checks++;
      if (count !== 3'd0 || valid !== 1'b0) begin
         failures++;
         $display("FAIL %s empty: count=%0d valid=%b required 0/0",
                  tag, count, valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; rx_data = 8'h00; rx_new = 1'b0;
      ready = 1'b0; clr_ovr = 1'b0;
      tick();
      tick();
      checks++;
      if ({rx_en, valid, data, count, afull, ovr, idle, busy} !== '0) begin
         failures++;
         $display("FAIL reset: rx_en=%b valid=%b data=%h count=%0d af=%b ovr=%b idle=%b busy=%b required all 0",
                  rx_en, valid, data, count, afull, ovr, idle, busy);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_enable();
      en = 1'b1;
      tick();
      checks++;
      if (rx_en !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL enable_edge1: rx_en=%b busy=%b required 0/1", rx_en, busy);
      end
      tick();
      checks++;
      if (rx_en !== 1'b1) begin
         failures++;
         $display("FAIL enable_edge2: rx_en=%b required 1", rx_en);
      end
   endtask

   task automatic test_basic();
      push_byte(8'h41, 1'b1);
      push_byte(8'h42, 1'b1);
      push_byte(8'h43, 1'b1);
      checks++;
      if (count !== 3'd3 || afull !== 1'b1) begin
         failures++;
         $display("FAIL basic_fill: count=%0d af=%b required 3/1", count, afull);
      end
      drain_sb("basic");
      checks++;
      if (afull !== 1'b0) begin
         failures++;
         $display("FAIL basic_af_clear: af=%b required 0", afull);
      end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i), 1'b1);
      push_byte(8'h99, 1'b0);
      checks++;
      if (ovr !== 1'b1 || count !== 3'd4) begin
         failures++;
         $display("FAIL overrun_set: ovr=%b count=%0d required 1/4", ovr, count);
      end
      clr_ovr = 1'b1;
      rx_data = 8'h9A;
      rx_new  = 1'b1;
      tick();
      clr_ovr = 1'b0;
      rx_new  = 1'b0;
      checks++;
      if (ovr !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set_wins: ovr=%b required 1", ovr);
      end
      tick();
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      checks++;
      if (ovr !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear: ovr=%b required 0", ovr);
      end
      drain_sb("overrun");
   endtask

   task automatic test_full_pop();
      logic [7:0] exp;
      for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i), 1'b1);
      ready   = 1'b1;
      rx_data = 8'h55;
      rx_new  = 1'b1;
      exp = sb.pop_front();
      sb.push_back(8'h55);
      checks++;
      if (data !== exp) begin
         failures++;
         $display("FAIL fullpop_head: data=%h required %h", data, exp);
      end
      tick();
      ready  = 1'b0;
      rx_new = 1'b0;
      checks++;
      if (count !== 3'd4 || ovr !== 1'b0) begin
         failures++;
         $display("FAIL fullpop_state: count=%0d ovr=%b required 4/0", count, ovr);
      end
      tick();
      drain_sb("fullpop");
   endtask

   task automatic test_drain();
      push_byte(8'h61, 1'b1);
      push_byte(8'h62, 1'b1);
      en = 1'b0;
      tick();
      checks++;
      if (rx_en !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL drain_enter: rx_en=%b busy=%b required 0/1", rx_en, busy);
      end
      push_byte(8'h77, 1'b0);
      checks++;
      if (count !== 3'd2) begin
         failures++;
         $display("FAIL drain_ignore_push: count=%0d required 2", count);
      end
      drain_sb("drain");
      tick();
      checks++;
      if (busy !== 1'b0 || rx_en !== 1'b0) begin
         failures++;
         $display("FAIL drain_off: busy=%b rx_en=%b required 0/0", busy, rx_en);
      end
      en = 1'b1;
      tick();
      tick();
   endtask

   task automatic idle_window(input string tag, input logic [7:0] b);
      int pulses = 0;
      int at = -1;
      rx_data = b;
      rx_new  = 1'b1;
      sb.push_back(b);
      for (int k = 1; k <= 40; k++) begin
         tick();
         rx_new = 1'b0;
         if (idle === 1'b1) begin
            pulses++;
            at = k;
         end
      end
      checks++;
      if (pulses != 1 || at != 16) begin
         failures++;
         $display("FAIL %s: pulses=%0d at_edge=%0d required 1 at 16",
                  tag, pulses, at);
      end
   endtask

   task automatic test_idle();
      tick();
      idle_window("idle_first", 8'h5A);
      idle_window("idle_rearm", 8'h5B);
      drain_sb("idle");
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      push_byte(8'h31, 1'b1);
      push_byte(8'h32, 1'b1);
      push_byte(8'h33, 1'b1);
      checks++;
      if (count !== 3'd3) begin
         failures++;
         $display("FAIL rstmid_pre: count=%0d required 3", count);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({rx_en, valid, data, count, afull, ovr, idle, busy} !== '0) begin
         failures++;
         $display("FAIL rstmid_async: rx_en=%b valid=%b data=%h count=%0d af=%b ovr=%b idle=%b busy=%b required all 0",
                  rx_en, valid, data, count, afull, ovr, idle, busy);
      end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (idle === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || count !== 3'd0) begin
         failures++;
         $display("FAIL rstmid_after: idle_pulses=%0d count=%0d required 0/0",
                  seen, count);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_enable();
      test_basic();
      test_overrun();
      test_full_pop();
      test_drain();
      test_idle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
